// File: rtl/oehb_dataless_fifo_if.sv
// Token handshake bundle for the dataless FIFO: input side, output side and
// the registered occupancy count.
interface oehb_dataless_fifo_if #(
  parameter int NUM_SLOTS = 4
) ();
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  // A token moves on a side only in a cycle where its valid and ready are both 1.
  // A raised valid stays raised until that transfer happens.
  logic             ins_valid;
  logic             ins_ready;
  logic             outs_valid;
  logic             outs_ready;
  logic [CNT_W-1:0] occupancy;

  modport slave (
    input  ins_valid,
    input  outs_ready,
    output ins_ready,
    output outs_valid,
    output occupancy
  );

  modport master (
    output ins_valid,
    output outs_ready,
    input  ins_ready,
    input  outs_valid,
    input  occupancy
  );
endinterface

// File: rtl/oehb_dataless_fifo.sv
// Dataless elastic FIFO: an occupancy counter that gives NUM_SLOTS tokens of slack,
// with an optional zero-latency bypass when TRANSPARENT=1.
module oehb_dataless_fifo #(
  parameter int NUM_SLOTS   = 4,
  parameter bit TRANSPARENT = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  oehb_dataless_fifo_if.slave    bus_if
);
  localparam int               CNT_W    = $clog2(NUM_SLOTS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);
  localparam logic [CNT_W:0]   MAX_SUM  = (CNT_W + 1)'(NUM_SLOTS);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_sum;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             ins_ready;
  logic             outs_valid;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  generate
    if (TRANSPARENT) begin : g_transparent
      // Empty bypass and push-on-full-pop both ride on these comb paths.
      assign outs_valid = !empty | bus_if.ins_valid;
      assign ins_ready  = !full  | bus_if.outs_ready;
    end else begin : g_registered
      assign outs_valid = !empty;
      assign ins_ready  = !full;
    end
  endgenerate

  assign push = bus_if.ins_valid & ins_ready;
  assign pop  = outs_valid & bus_if.outs_ready;

  // One guard bit so an underflow or overflow would show up as a value above MAX_SUM.
  assign cnt_sum = {1'b0, cnt_q}
                 + {{CNT_W{1'b0}}, push}
                 - {{CNT_W{1'b0}}, pop};

  always_comb begin
    cnt_d = cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      assert (cnt_sum <= MAX_SUM);
      assert (cnt_q <= FULL_CNT);
    end
  end

  assign bus_if.ins_ready  = ins_ready;
  assign bus_if.outs_valid = outs_valid;
  assign bus_if.occupancy  = cnt_q;
endmodule

// File: tb/tb_oehb_dataless_fifo.sv
// Directed and randomised checks of the dataless FIFO in registered mode,
// transparent mode and the single-slot configuration.
module tb_oehb_dataless_fifo;
  logic clk;
  logic rst;

  int n_checks;
  int n_pass;
  int m0;
  int m1;

  oehb_dataless_fifo_if #(.NUM_SLOTS(4)) if0 ();
  oehb_dataless_fifo_if #(.NUM_SLOTS(4)) if1 ();
  oehb_dataless_fifo_if #(.NUM_SLOTS(1)) if2 ();

  oehb_dataless_fifo #(.NUM_SLOTS(4), .TRANSPARENT(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus_if(if0));
  oehb_dataless_fifo #(.NUM_SLOTS(4), .TRANSPARENT(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus_if(if1));
  oehb_dataless_fifo #(.NUM_SLOTS(1), .TRANSPARENT(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus_if(if2));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model of the counter
  function automatic int exp_ready(input bit t, input int m, input int orr, input int n);
    return ((m != n) || (t && orr != 0)) ? 1 : 0;
  endfunction

  function automatic int exp_valid(input bit t, input int m, input int iv);
    return ((m != 0) || (t && iv != 0)) ? 1 : 0;
  endfunction

  task automatic idle_all();
    if0.ins_valid = 1'b0; if0.outs_ready = 1'b0;
    if1.ins_valid = 1'b0; if1.outs_ready = 1'b0;
    if2.ins_valid = 1'b0; if2.outs_ready = 1'b0;
  endtask

  // Drives both 4-slot DUTs for one cycle, checks them against the model, advances it.
  task automatic rand_step(input int iv0, input int or0, input int iv1, input int or1);
    int r0, v0, r1, v1;
    if0.ins_valid = iv0[0]; if0.outs_ready = or0[0];
    if1.ins_valid = iv1[0]; if1.outs_ready = or1[0];
    #1;
    r0 = exp_ready(1'b0, m0, or0, 4); v0 = exp_valid(1'b0, m0, iv0);
    r1 = exp_ready(1'b1, m1, or1, 4); v1 = exp_valid(1'b1, m1, iv1);
    check("rnd_occ0",  int'(if0.occupancy), m0);
    check("rnd_rdy0",  int'(if0.ins_ready), r0);
    check("rnd_vld0",  int'(if0.outs_valid), v0);
    check("rnd_occ1",  int'(if1.occupancy), m1);
    check("rnd_rdy1",  int'(if1.ins_ready), r1);
    check("rnd_vld1",  int'(if1.outs_valid), v1);
    m0 = m0 + (iv0 & r0) - (v0 & or0);
    m1 = m1 + (iv1 & r1) - (v1 & or1);
    @(negedge clk);
  endtask

  initial begin
    int occ_tab2[6];
    int rdy_tab2[6];
    int occ_tab3[4];
    int rdy_tab3[4];
    int cnt;

    occ_tab2 = '{0, 1, 2, 3, 4, 4};
    rdy_tab2 = '{1, 1, 1, 1, 0, 0};
    occ_tab3 = '{4, 3, 3, 3};
    rdy_tab3 = '{0, 1, 1, 1};
    n_checks = 0;
    n_pass   = 0;
    m0 = 0;
    m1 = 0;

    idle_all();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_occ0", int'(if0.occupancy), 0);
    check("rst_rdy0", int'(if0.ins_ready), 1);
    check("rst_vld0", int'(if0.outs_valid), 0);
    check("rst_occ1", int'(if1.occupancy), 0);
    check("rst_rdy1", int'(if1.ins_ready), 1);
    check("rst_vld1_idle", int'(if1.outs_valid), 0);
    if1.ins_valid = 1'b1;
    #1;
    check("rst_vld1_follow", int'(if1.outs_valid), 1);
    if1.ins_valid = 1'b0;
    @(negedge clk);

    // Registered mode fills to four and then stalls
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if0.ins_valid = 1'b1; if0.outs_ready = 1'b0;
      #1;
      check($sformatf("fill_occ%0d", k), int'(if0.occupancy), occ_tab2[k]);
      check($sformatf("fill_rdy%0d", k), int'(if0.ins_ready), rdy_tab2[k]);
      if (if0.ins_ready) cnt++;
      @(negedge clk);
    end
    check("fill_occ_end", int'(if0.occupancy), 4);
    check("fill_pushes", cnt, 4);

    // Full with push and pop offered: first cycle pops only, then steady at 3
    for (int k = 0; k < 4; k++) begin
      if0.ins_valid = 1'b1; if0.outs_ready = 1'b1;
      #1;
      check($sformatf("full_occ%0d", k), int'(if0.occupancy), occ_tab3[k]);
      check($sformatf("full_rdy%0d", k), int'(if0.ins_ready), rdy_tab3[k]);
      check($sformatf("full_vld%0d", k), int'(if0.outs_valid), 1);
      @(negedge clk);
    end
    check("full_occ_end", int'(if0.occupancy), 3);
    if0.ins_valid = 1'b0; if0.outs_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("drain0_occ", int'(if0.occupancy), 0);
    check("drain0_vld", int'(if0.outs_valid), 0);
    if0.outs_ready = 1'b0;
    @(negedge clk);

    // Transparent mode bypass from empty
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if1.ins_valid = 1'b1; if1.outs_ready = 1'b1;
      #1;
      check($sformatf("byp_vld%0d", k), int'(if1.outs_valid), 1);
      check($sformatf("byp_occ%0d", k), int'(if1.occupancy), 0);
      if (if1.outs_valid && if1.ins_ready) cnt++;
      @(negedge clk);
    end
    check("byp_tokens", cnt, 10);
    check("byp_occ_end", int'(if1.occupancy), 0);

    // Transparent mode: full with consumer ready still accepts
    if1.ins_valid = 1'b1; if1.outs_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("tfull_occ", int'(if1.occupancy), 4);
    check("tfull_rdy_stall", int'(if1.ins_ready), 0);
    for (int k = 0; k < 3; k++) begin
      if1.ins_valid = 1'b1; if1.outs_ready = 1'b1;
      #1;
      check($sformatf("tfull_rdy%0d", k), int'(if1.ins_ready), 1);
      check($sformatf("tfull_vld%0d", k), int'(if1.outs_valid), 1);
      @(negedge clk);
      #1;
      check($sformatf("tfull_hold%0d", k), int'(if1.occupancy), 4);
    end
    if1.ins_valid = 1'b0; if1.outs_ready = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    #1;
    check("drain1_occ", int'(if1.occupancy), 0);
    if1.outs_ready = 1'b0;
    @(negedge clk);

    // Single slot: half throughput with an always-ready consumer
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if2.ins_valid = 1'b1; if2.outs_ready = 1'b1;
      #1;
      check($sformatf("one_occ%0d", k), int'(if2.occupancy), k % 2);
      check($sformatf("one_rdy%0d", k), int'(if2.ins_ready), (k % 2 == 0) ? 1 : 0);
      if (if2.outs_valid) cnt++;
      @(negedge clk);
    end
    check("one_pops", cnt, 4);
    idle_all();
    @(negedge clk);

    // Random traffic with a mid-run reset while the registered FIFO holds three
    m0 = int'(if0.occupancy);
    m1 = int'(if1.occupancy);
    check("rnd_start0", m0, 0);
    check("rnd_start1", m1, 0);
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) begin
        for (int k = 0; k < 8 && m0 != 3; k++) begin
          rand_step((m0 < 3) ? 1 : 0, (m0 > 3) ? 1 : 0, 0, 0);
        end
        #1;
        check("pre_rst_occ0", int'(if0.occupancy), 3);
        rst = 1'b1;
        if0.ins_valid = 1'b1; if0.outs_ready = 1'b1;
        if1.ins_valid = 1'b1; if1.outs_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m0 = 0;
        m1 = 0;
        idle_all();
        #1;
        check("post_rst_occ0", int'(if0.occupancy), 0);
        check("post_rst_occ1", int'(if1.occupancy), 0);
      end
      rand_step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
